// File: rtl/jk_bank_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// jk_bank_sequencer
//
// A WIDTH-bit bank of JK cells driven by a small command sequencer. A command
// ({J,K} plus a bit mask) is captured when requested from IDLE. It is then
// applied to all masked bits in one cycle (APPLY) or to one bit per cycle, LSB
// first (SWEEP). Completion is signalled by a one-cycle pulse in DONE.
//
// Handshake: iReq is a level. The requester holds it until it sees oAck high
// and drops it in that same cycle. A request is accepted at a rising edge
// while the FSM is in IDLE. All command inputs, including iReq, are ignored
// from acceptance until the FSM is back in IDLE.
//
// Ports
//   iClk     clock, rising edge only
//   iRst_n   asynchronous active-low reset
//   iClr     synchronous clear/abort, highest synchronous priority
//   iReq     command request (level, held until oAck)
//   iCmd     {J,K}: 00 hold, 01 clear, 10 set, 11 toggle
//   iMask    bits the command applies to (1 = affected)
//   iSweep   0 = all masked bits at once, 1 = one bit per cycle, LSB first
//   oQ       current JK bank state
//   oBusy    high in every state except IDLE (registered)
//   oAck     one-cycle completion pulse (registered)
//   oState   FSM state for debug/observation (0 IDLE, 1 APPLY, 2 SWEEP, 3 DONE)
// -----------------------------------------------------------------------------
module jk_bank_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iClr,
    input  logic             iReq,
    input  logic [1:0]       iCmd,
    input  logic [WIDTH-1:0] iMask,
    input  logic             iSweep,
    output logic [WIDTH-1:0] oQ,
    output logic             oBusy,
    output logic             oAck,
    output logic [1:0]       oState
);

    localparam int IDXW = $clog2(WIDTH);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  q, q_nxt;
    logic [IDXW-1:0]   idx, idx_nxt;
    logic [1:0]        cmd_q;
    logic [WIDTH-1:0]  mask_q;
    logic              capture;
    logic [WIDTH-1:0]  apply_mask;
    logic              busy_q, ack_q;

    // The apply mode is not kept in a separate register: once captured, it is
    // fully encoded by whether the FSM sits in APPLY or SWEEP.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        capture    = 1'b0;
        apply_mask = '0;
        q_nxt      = q;

        case (state)
            IDLE: begin
                if (iReq) begin
                    capture   = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = iSweep ? SWEEP : APPLY;
                end
            end
            APPLY: begin
                apply_mask = mask_q;
                state_nxt  = DONE;
            end
            SWEEP: begin
                // Only the current index may change; masked-off bits still
                // consume their cycle so the sweep length is always WIDTH.
                for (int i = 0; i < WIDTH; i++) begin
                    apply_mask[i] = mask_q[i] && (idx == IDXW'(i));
                end
                if (idx == LAST_IDX) begin
                    idx_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // JK rule per selected cell.
        for (int i = 0; i < WIDTH; i++) begin
            if (apply_mask[i]) begin
                case (cmd_q)
                    2'b01:   q_nxt[i] = 1'b0;
                    2'b10:   q_nxt[i] = 1'b1;
                    2'b11:   q_nxt[i] = ~q[i];
                    default: q_nxt[i] = q[i];
                endcase
            end
        end

        // Clear overrides everything, including a same-cycle request in IDLE.
        if (iClr) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            q_nxt     = '0;
            capture   = 1'b0;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state  <= IDLE;
            q      <= '0;
            idx    <= '0;
            cmd_q  <= '0;
            mask_q <= '0;
            busy_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            idx   <= idx_nxt;
            if (iClr) begin
                cmd_q  <= '0;
                mask_q <= '0;
            end else if (capture) begin
                cmd_q  <= iCmd;
                mask_q <= iMask;
            end
            // Registered from the next state so both flags line up with the
            // state they describe and never glitch.
            busy_q <= (state_nxt != IDLE);
            ack_q  <= (state_nxt == DONE);
        end
    end

    assign oQ     = q;
    assign oBusy  = busy_q;
    assign oAck   = ack_q;
    assign oState = state;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
`timescale 1ns/1ps
module tb_jk_bank_sequencer;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         clr;
    logic         req;
    logic [1:0]   cmd;
    logic [W-1:0] mask;
    logic         sweep;
    logic [W-1:0] q;
    logic         busy;
    logic         ack;
    logic [1:0]   state;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [1:0]   cmd;
        logic [W-1:0] mask;
        logic         sweep;
        logic [W-1:0] q_exp;
        int           lat_exp;
    } vec_t;

    vec_t vecs[9];

    jk_bank_sequencer #(.WIDTH(W)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .iClr   (clr),
        .iReq   (req),
        .iCmd   (cmd),
        .iMask  (mask),
        .iSweep (sweep),
        .oQ     (q),
        .oBusy  (busy),
        .oAck   (ack),
        .oState (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req_v);
        end
    endtask

    // Waits (at negedges) for oAck, bounded. n counts negedges since the call.
    task automatic wait_ack(input int bound, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < bound) begin
            @(negedge clk);
            n++;
            if (ack) seen = 1'b1;
        end
    endtask

    // Driver + scoreboard: issue one command, scramble inputs while busy,
    // compare result and latency when oAck shows up.
    task automatic run_cmd(input logic [1:0] c, input logic [W-1:0] m, input logic s,
                           input logic [W-1:0] q_exp, input int lat_exp, input string tag);
        int n;
        bit seen;
        @(negedge clk);
        cmd = c; mask = m; sweep = s; req = 1'b1;
        @(posedge clk);
        exp_q.push_back(q_exp);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            check({tag, " busy"}, {31'd0, busy}, 32'd1);
            if (ack) begin
                seen = 1'b1;
                req  = 1'b0;
            end else begin
                cmd   = 2'($urandom_range(0, 3));
                mask  = 8'($urandom_range(0, 255));
                sweep = 1'($urandom_range(0, 1));
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s ack_timeout: got no ack, expected ack within 40 cycles", tag);
            req = 1'b0;
            void'(exp_q.pop_front());
        end else begin
            check({tag, " latency"}, 32'(n), 32'(lat_exp));
            check({tag, " q"}, {24'd0, q}, {24'd0, exp_q.pop_front()});
        end
    endtask

    initial begin
        int n;
        bit seen;
        int acks;

        // {cmd, mask, sweep, expected q, expected latency}, chained from 0x00
        vecs[0] = '{2'b10, 8'hA5, 1'b0, 8'hA5, 2};
        vecs[1] = '{2'b11, 8'hFF, 1'b1, 8'h5A, 9};
        vecs[2] = '{2'b01, 8'h0F, 1'b0, 8'h50, 2};
        vecs[3] = '{2'b00, 8'hFF, 1'b1, 8'h50, 9};
        vecs[4] = '{2'b10, 8'h00, 1'b0, 8'h50, 2};
        vecs[5] = '{2'b11, 8'h3C, 1'b0, 8'h6C, 2};
        vecs[6] = '{2'b10, 8'h81, 1'b1, 8'hED, 9};
        vecs[7] = '{2'b01, 8'hF0, 1'b1, 8'h0D, 9};
        vecs[8] = '{2'b11, 8'h00, 1'b1, 8'h0D, 9};

        rst_n = 1'b0; clr = 1'b0; req = 1'b0; cmd = '0; mask = '0; sweep = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset q", {24'd0, q}, 32'h00);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset ack", {31'd0, ack}, 32'd0);
        check("reset state", {30'd0, state}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset idle q", {24'd0, q}, 32'h00);

        // table-driven commands
        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].cmd, vecs[i].mask, vecs[i].sweep, vecs[i].q_exp,
                    vecs[i].lat_exp, $sformatf("vec%0d", i));
        end

        // clear back to zero from idle
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("idle clr q", {24'd0, q}, 32'h00);

        // sweep toggle trace: bit k flips at edge k+1 after acceptance
        run_cmd(2'b10, 8'hA5, 1'b0, 8'hA5, 2, "set_a5");
        @(negedge clk);
        cmd = 2'b11; mask = 8'hFF; sweep = 1'b1; req = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            int t;
            @(negedge clk);
            t = (1 << (k - 1)) - 1;
            check($sformatf("sweep trace q n=%0d", k), {24'd0, q}, {24'd0, 8'hA5 ^ 8'(t)});
            check($sformatf("sweep trace ack n=%0d", k), {31'd0, ack}, (k == 9) ? 32'd1 : 32'd0);
            if (ack) req = 1'b0;
        end
        req = 1'b0;

        // back-to-back: request held through the first ack
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        run_cmd(2'b10, 8'hFF, 1'b0, 8'hFF, 2, "set_ff");
        @(negedge clk);
        cmd = 2'b01; mask = 8'h0F; sweep = 1'b0; req = 1'b1;
        @(posedge clk);
        wait_ack(20, n, seen);
        check("b2b first ack seen", {31'd0, seen}, 32'd1);
        check("b2b first q", {24'd0, q}, 32'hF0);
        cmd = 2'b10; mask = 8'h01;
        @(negedge clk);
        check("b2b idle gap busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("b2b second accepted busy", {31'd0, busy}, 32'd1);
        wait_ack(20, n, seen);
        check("b2b second ack seen", {31'd0, seen}, 32'd1);
        check("b2b second q", {24'd0, q}, 32'hF1);
        req = 1'b0;

        // clear-abort during sweep at idx=3
        @(negedge clk);
        cmd = 2'b11; mask = 8'hFF; sweep = 1'b1; req = 1'b1;
        @(posedge clk);
        repeat (4) @(negedge clk);
        check("abort pre state", {30'd0, state}, 32'd2);
        check("abort pre q", {24'd0, q}, 32'hF6);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        req = 1'b0;
        check("abort q", {24'd0, q}, 32'h00);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort state", {30'd0, state}, 32'd0);
        acks = 0;
        for (int k = 0; k < 12; k++) begin
            if (ack) acks++;
            @(negedge clk);
        end
        check("abort no ack", 32'(acks), 32'd0);

        // clear and request together in idle: clear wins
        @(negedge clk);
        clr = 1'b1; req = 1'b1; cmd = 2'b10; mask = 8'hFF; sweep = 1'b0;
        @(negedge clk);
        check("clr+req busy", {31'd0, busy}, 32'd0);
        check("clr+req q", {24'd0, q}, 32'h00);
        clr = 1'b0;
        @(negedge clk);
        check("req after clr busy", {31'd0, busy}, 32'd1);
        wait_ack(20, n, seen);
        check("req after clr ack seen", {31'd0, seen}, 32'd1);
        check("req after clr q", {24'd0, q}, 32'hFF);
        req = 1'b0;

        // asynchronous reset mid-sweep
        @(negedge clk);
        cmd = 2'b01; mask = 8'hFF; sweep = 1'b1; req = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        check("mid-sweep q before reset", {24'd0, q}, 32'hFC);
        #1 rst_n = 1'b0;
        #1;
        check("async reset q", {24'd0, q}, 32'h00);
        check("async reset busy", {31'd0, busy}, 32'd0);
        check("async reset ack", {31'd0, ack}, 32'd0);
        check("async reset state", {30'd0, state}, 32'd0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ack || busy || (q != 8'h00)) acks++;
        end
        check("post-reset idle activity", 32'(acks), 32'd0);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
